btb_nway: RTL and testbench
===========================

BTB_NWAY -- requirements
Module: btb_nway

Interface
REQ-001 SHALL have parameter NUM_SETS, default 8, meaning set count; power of two, 2..256.
REQ-002 SHALL have parameter NUM_WAYS, default 2, meaning associativity; 1, 2 or 4.
REQ-003 SHALL have parameter XLEN, default 32, meaning PC/target width.
REQ-004 SHALL have port clk, input, 1, the one clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rd_pc, input, XLEN, IF-stage lookup PC.
REQ-007 SHALL have port rd_en, input, 1, lookup is real and may touch LRU.
REQ-008 SHALL have port rd_hit, output, 1, valid tag match in the indexed set.
REQ-009 SHALL have port rd_taken, output, 1, predicted taken: MSB of the hit entry's state, 0 on miss.
REQ-010 SHALL have port rd_target, output, XLEN, target of the hit way, 0 on miss.
REQ-011 SHALL have port upd_valid, input, 1, resolved branch update this cycle.
REQ-012 SHALL have port upd_pc, input, XLEN, PC of the resolved branch.
REQ-013 SHALL have port upd_target, input, XLEN, resolved target.
REQ-014 SHALL have port upd_taken, input, 1, resolved outcome.
REQ-015 SHALL have port inv_all, input, 1, clear all valid bits.

Function
REQ-016 SHALL split the PC as index = pc[IDX+1:2] and tag = pc[XLEN-1:IDX+2], where IDX = log2(NUM_SETS), and SHALL ignore pc[1:0].
REQ-017 SHALL store per way: valid, tag, target and 2-bit state; encoding 00 strong-NT, 01 weak-NT, 11 weak-T, 10 strong-T.
REQ-018 SHALL drive rd_hit, rd_taken and rd_target combinationally from stored state (zero-cycle lookup); multiple matching ways resolve to the lowest index.
REQ-019 SHALL, on an update hit, step the state taken 00->01->11->10 (saturating at 10), not-taken 10->11->01->00 (saturating at 00), and overwrite the target only when upd_taken=1.
REQ-020 SHALL, on an update miss with upd_taken=1, allocate the victim way: valid=1, tag, target, state 11.
REQ-021 SHALL make no change on an update miss with upd_taken=0.
REQ-022 SHALL select as victim the lowest-index invalid way; if no way is invalid, the way with the maximum LRU age.
REQ-023 SHALL keep a clog2(NUM_WAYS)-bit age per way; a touch of way w increments every age below age[w] and zeroes age[w].
REQ-024 SHALL touch the hit way on rd_en&&rd_hit, and the hit or allocated way on an update.
REQ-025 SHALL, when read and update target the same set in one cycle, apply only the update touch.
REQ-026 SHALL give inv_all priority over upd_valid: all valid=0 next cycle, the update dropped, ages unchanged.
REQ-027 SHALL return pre-update contents on a same-cycle lookup of the entry being updated (write visible next cycle) unless REQ-033 applies.

Reset
REQ-028 SHALL, while rst=1: all valid=0, way w age=w, storage updates ignored, rd_hit=0, rd_taken=0, rd_target=0.
REQ-029 SHALL resume normal operation on the first edge after rst falls; an update presented during reset is lost.

Configuration
REQ-030 SHALL compile a same-cycle update bypass under macro BTB_BYPASS_EN.
REQ-031 SHALL, with BTB_BYPASS_EN defined and upd_valid=1 with rd_pc index/tag equal to upd_pc, output rd_hit=1, rd_taken = MSB of the post-update state, rd_target = post-update target.
REQ-032 SHALL, with the update being a not-taken miss and BTB_BYPASS_EN defined, use no bypass.
REQ-033 SHALL, without BTB_BYPASS_EN, behave per REQ-027 and synthesise no bypass logic.

Structure
REQ-034 SHALL have package btb_pkg hold: the state typedef, the four encoding constants, the next-state function, and idx_w/tag_w width functions.
REQ-035 SHALL have one sub-module, btb_lru: per-set ages, touch port, victim output; instantiated once, indexed by set.

Verification
REQ-036 SHALL test: reset, then lookup 0x0000_1000 -> rd_hit=0, rd_taken=0, rd_target=0.
REQ-037 SHALL test: update pc=0x1000, target 0x2000, taken -> next-cycle lookup hit, taken=1, target 0x2000, state 11.
REQ-038 SHALL test: three not-taken updates of 0x1000 -> states 01, 00, 00; rd_taken=0, target still 0x2000.
REQ-039 SHALL test: NUM_WAYS=2, taken updates 0x1000, 0x1020, then read 0x1000, then update 0x1040 taken (same set) -> 0x1020 evicted, 0x1000 and 0x1040 hit.
REQ-040 SHALL test: lookup and update 0x3000 same cycle -> miss without BTB_BYPASS_EN; hit, target forwarded with it.
REQ-041 SHALL test: inv_all together with upd_valid -> all lookups miss next cycle; rst mid-traffic -> outputs 0 while high.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and helpers for the n-way branch target buffer.
package btb_pkg;

    // Two-bit direction counter; the MSB is the taken prediction.
    typedef logic [1:0] btb_state_t;

    localparam btb_state_t ST_SNT = 2'b00;  // strong not-taken
    localparam btb_state_t ST_WNT = 2'b01;  // weak not-taken
    localparam btb_state_t ST_WT  = 2'b11;  // weak taken
    localparam btb_state_t ST_STK = 2'b10;  // strong taken

    // Saturating step of the direction counter toward the resolved outcome.
    function automatic btb_state_t next_state(input btb_state_t cur, input logic taken);
        btb_state_t nxt;
        nxt = cur;
        case (cur)
            ST_SNT:  nxt = taken ? ST_WNT : ST_SNT;
            ST_WNT:  nxt = taken ? ST_WT  : ST_SNT;
            ST_WT:   nxt = taken ? ST_STK : ST_WNT;
            ST_STK:  nxt = taken ? ST_STK : ST_WT;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    function automatic int unsigned idx_w(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned num_sets);
        return xlen - idx_w(num_sets) - 2;
    endfunction

    // Way index / age width; a direct-mapped buffer still keeps one bit.
    function automatic int unsigned way_w(input int unsigned num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/btb_lru.sv
// Per-set LRU ages for the BTB. Ages form a permutation of 0..NUM_WAYS-1;
// the oldest way of the queried set is reported as the replacement candidate.
module btb_lru
    import btb_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned NUM_WAYS = 2,
    localparam int unsigned IDX_W = idx_w(NUM_SETS),
    localparam int unsigned WAY_W = way_w(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_touch,
    input  logic [IDX_W-1:0] upd_set,
    input  logic [WAY_W-1:0] upd_way,
    input  logic             rd_touch,
    input  logic [IDX_W-1:0] rd_set,
    input  logic [WAY_W-1:0] rd_way,
    input  logic [IDX_W-1:0] query_set,
    output logic [WAY_W-1:0] lru_way_c
);

    logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];
    logic [NUM_SETS-1:0] set_touch;
    logic [WAY_W-1:0]    set_way [NUM_SETS];

    // Route each touch to its set; the two touches never share a set.
    always_comb begin
        for (int s = 0; s < int'(NUM_SETS); s++) begin
            set_touch[s] = (upd_touch && (IDX_W'(s) == upd_set)) ||
                           (rd_touch  && (IDX_W'(s) == rd_set));
            set_way[s]   = (upd_touch && (IDX_W'(s) == upd_set)) ? upd_way : rd_way;
        end
    end

    // Touched way becomes youngest; ways younger than it age by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                for (int w = 0; w < int'(NUM_WAYS); w++) begin
                    age[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                if (set_touch[s]) begin
                    for (int w = 0; w < int'(NUM_WAYS); w++) begin
                        if (WAY_W'(w) == set_way[s]) begin
                            age[s][w] <= '0;
                        end else if (age[s][w] < age[s][set_way[s]]) begin
                            age[s][w] <= age[s][w] + WAY_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Oldest way of the queried set (age NUM_WAYS-1).
    always_comb begin
        lru_way_c = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (age[query_set][w] == WAY_W'(NUM_WAYS - 1)) begin
                lru_way_c = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/btb_nway.sv
// Set-associative branch target buffer with zero-cycle lookup and LRU
// replacement. Define BTB_BYPASS_EN to forward a same-cycle update of the
// looked-up PC to the read outputs.
module btb_nway
    import btb_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc,
    input  logic            rd_en,
    output logic            rd_hit,
    output logic            rd_taken,
    output logic [XLEN-1:0] rd_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            inv_all
);

    localparam int unsigned IDX_W = idx_w(NUM_SETS);
    localparam int unsigned TAG_W = tag_w(XLEN, NUM_SETS);
    localparam int unsigned WAY_W = way_w(NUM_WAYS);

    logic [NUM_WAYS-1:0] valid   [NUM_SETS];
    logic [TAG_W-1:0]    tags    [NUM_SETS][NUM_WAYS];
    logic [XLEN-1:0]     targets [NUM_SETS][NUM_WAYS];
    btb_state_t          states  [NUM_SETS][NUM_WAYS];

    logic [IDX_W-1:0] r_idx, u_idx;
    logic [TAG_W-1:0] r_tag, u_tag;
    logic             r_hit, u_hit;
    logic [WAY_W-1:0] r_way, u_way, vic_way, lru_way, wr_way;
    logic             upd_write, rd_touch;
    btb_state_t       new_state;
    logic [XLEN-1:0]  new_target;
    logic             unused_pc_lsb;

    assign r_idx = rd_pc[IDX_W+1:2];
    assign r_tag = rd_pc[XLEN-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX_W+2];
    assign unused_pc_lsb = ^{rd_pc[1:0], upd_pc[1:0]};

    // Tag compare for lookup and update ports; the lowest matching way wins.
    always_comb begin
        r_hit = 1'b0;
        r_way = '0;
        u_hit = 1'b0;
        u_way = '0;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (valid[r_idx][w] && (tags[r_idx][w] == r_tag)) begin
                r_hit = 1'b1;
                r_way = WAY_W'(w);
            end
            if (valid[u_idx][w] && (tags[u_idx][w] == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, otherwise the oldest way.
    always_comb begin
        vic_way = lru_way;
        for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
            if (!valid[u_idx][w]) begin
                vic_way = WAY_W'(w);
            end
        end
    end

    // Post-update entry contents and the LRU touches for this cycle.
    always_comb begin
        upd_write  = upd_valid && !inv_all && !rst && (u_hit || upd_taken);
        wr_way     = u_hit ? u_way : vic_way;
        new_state  = u_hit ? next_state(states[u_idx][u_way], upd_taken) : ST_WT;
        new_target = (u_hit && !upd_taken) ? targets[u_idx][u_way] : upd_target;
        rd_touch   = rd_en && r_hit && !rst && !inv_all &&
                     !(upd_valid && (u_idx == r_idx));
    end

    // Entry storage; invalidate-all and reset only clear valid bits.
    always_ff @(posedge clk) begin
        if (rst || inv_all) begin
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                valid[s] <= '0;
            end
        end else if (upd_write) begin
            valid[u_idx][wr_way]   <= 1'b1;
            tags[u_idx][wr_way]    <= u_tag;
            targets[u_idx][wr_way] <= new_target;
            states[u_idx][wr_way]  <= new_state;
        end
    end

    btb_lru #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .clk       (clk),
        .rst       (rst),
        .upd_touch (upd_write),
        .upd_set   (u_idx),
        .upd_way   (wr_way),
        .rd_touch  (rd_touch),
        .rd_set    (r_idx),
        .rd_way    (r_way),
        .query_set (u_idx),
        .lru_way_c (lru_way)
    );

`ifdef BTB_BYPASS_EN
    logic byp;
    assign byp = upd_write && (rd_pc[XLEN-1:2] == upd_pc[XLEN-1:2]);
`endif

    // Zero-cycle lookup outputs, forced low during reset.
    always_comb begin
        rd_hit    = 1'b0;
        rd_taken  = 1'b0;
        rd_target = '0;
`ifdef BTB_BYPASS_EN
        if (byp) begin
            rd_hit    = 1'b1;
            rd_taken  = new_state[1];
            rd_target = new_target;
        end else
`endif
        if (r_hit && !rst) begin
            rd_hit    = 1'b1;
            rd_taken  = states[r_idx][r_way][1];
            rd_target = targets[r_idx][r_way];
        end
    end

endmodule

// File: tb/tb_btb_nway.sv
// Self-checking bench for btb_nway: directed scenarios plus randomized traffic
// compared against a per-set recency-list model of the buffer.
module tb_btb_nway;

    localparam int unsigned NS   = 8;
    localparam int unsigned NW   = 2;
    localparam int unsigned XL   = 32;
    localparam int unsigned IDXW = 3;

    logic          clk = 1'b0;
    logic          rst, rd_en, rd_hit, rd_taken, upd_valid, upd_taken, inv_all;
    logic [XL-1:0] rd_pc, rd_target, upd_pc, upd_target;

    int errors = 0;
    int checks = 0;

    // Reference model: entries with a 0..3 confidence count (>=2 means taken)
    // and, per set, a list of ways ordered from most to least recently used.
    bit            m_v   [NS][NW];
    logic [XL-1:0] m_tag [NS][NW];
    logic [XL-1:0] m_tgt [NS][NW];
    int            m_cnt [NS][NW];
    int            lru_q [NS][$];

    always #5 clk = ~clk;

    btb_nway #(.NUM_SETS(NS), .NUM_WAYS(NW), .XLEN(XL)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_pc      (rd_pc),
        .rd_en      (rd_en),
        .rd_hit     (rd_hit),
        .rd_taken   (rd_taken),
        .rd_target  (rd_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken),
        .inv_all    (inv_all)
    );

    task automatic check_eq(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic eh, input logic et, input logic [XL-1:0] eg);
        check_eq({tag, "/hit"},    XL'(rd_hit),   XL'(eh));
        check_eq({tag, "/taken"},  XL'(rd_taken), XL'(et));
        check_eq({tag, "/target"}, rd_target,     eg);
    endtask

    function automatic int set_of(input logic [XL-1:0] pc);
        return int'((pc >> 2) % NS);
    endfunction

    function automatic logic [XL-1:0] tag_of(input logic [XL-1:0] pc);
        return pc >> (2 + IDXW);
    endfunction

    function automatic int find_way(input logic [XL-1:0] pc);
        int s;
        s = set_of(pc);
        for (int w = 0; w < int'(NW); w++) begin
            if (m_v[s][w] && (m_tag[s][w] == tag_of(pc))) return w;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int s = 0; s < int'(NS); s++) begin
            lru_q[s].delete();
            for (int w = 0; w < int'(NW); w++) begin
                m_v[s][w] = 1'b0;
                lru_q[s].push_back(w);
            end
        end
    endtask

    task automatic m_touch(input int s, input int w);
        for (int i = 0; i < lru_q[s].size(); i++) begin
            if (lru_q[s][i] == w) begin
                lru_q[s].delete(i);
                break;
            end
        end
        lru_q[s].push_front(w);
    endtask

    function automatic int m_victim(input int s);
        for (int w = 0; w < int'(NW); w++) begin
            if (!m_v[s][w]) return w;
        end
        return lru_q[s][lru_q[s].size() - 1];
    endfunction

    // What the current update would leave in its entry, if it writes at all.
    task automatic m_post(output bit writes, output int cnt, output logic [XL-1:0] tgt);
        int s, w;
        s = set_of(upd_pc);
        w = find_way(upd_pc);
        writes = 1'b0;
        cnt    = 0;
        tgt    = '0;
        if (w >= 0) begin
            writes = 1'b1;
            if (upd_taken) cnt = (m_cnt[s][w] == 3) ? 3 : m_cnt[s][w] + 1;
            else           cnt = (m_cnt[s][w] == 0) ? 0 : m_cnt[s][w] - 1;
            tgt = upd_taken ? upd_target : m_tgt[s][w];
        end else if (upd_taken) begin
            writes = 1'b1;
            cnt    = 2;
            tgt    = upd_target;
        end
    endtask

    task automatic model_expect(output logic eh, output logic et, output logic [XL-1:0] eg);
        int s, w;
        eh = 1'b0;
        et = 1'b0;
        eg = '0;
        if (rst) return;
`ifdef BTB_BYPASS_EN
        if (upd_valid && !inv_all && (rd_pc[XL-1:2] == upd_pc[XL-1:2])) begin
            bit wr;
            int c;
            logic [XL-1:0] t;
            m_post(wr, c, t);
            if (wr) begin
                eh = 1'b1;
                et = (c >= 2);
                eg = t;
                return;
            end
        end
`endif
        s = set_of(rd_pc);
        w = find_way(rd_pc);
        if (w >= 0) begin
            eh = 1'b1;
            et = (m_cnt[s][w] >= 2);
            eg = m_tgt[s][w];
        end
    endtask

    task automatic model_step();
        bit wr;
        int c, rs, rw, us, uw;
        logic [XL-1:0] t;
        if (rst) begin
            m_reset();
            return;
        end
        if (inv_all) begin
            for (int s = 0; s < int'(NS); s++)
                for (int w = 0; w < int'(NW); w++) m_v[s][w] = 1'b0;
            return;
        end
        rs = set_of(rd_pc);
        rw = find_way(rd_pc);
        us = set_of(upd_pc);
        uw = find_way(upd_pc);
        if (rd_en && (rw >= 0) && !(upd_valid && (us == rs))) m_touch(rs, rw);
        if (upd_valid) begin
            m_post(wr, c, t);
            if (wr) begin
                if (uw < 0) begin
                    uw = m_victim(us);
                    m_v[us][uw]   = 1'b1;
                    m_tag[us][uw] = tag_of(upd_pc);
                end
                m_cnt[us][uw] = c;
                m_tgt[us][uw] = t;
                m_touch(us, uw);
            end
        end
    endtask

    // Called shortly after a rising edge with inputs applied: check against
    // the model in the low phase, then advance the model on the next edge.
    task automatic tick(input string tag);
        logic eh, et;
        logic [XL-1:0] eg;
        #3;
        model_expect(eh, et, eg);
        check_out(tag, eh, et, eg);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic probe(input logic [XL-1:0] pc, input logic eh, input logic et,
                         input logic [XL-1:0] eg, input string tag);
        rd_pc     = pc;
        rd_en     = 1'b1;
        upd_valid = 1'b0;
        inv_all   = 1'b0;
        #2;
        check_out(tag, eh, et, eg);
        tick({tag, "/model"});
    endtask

    task automatic upd(input logic [XL-1:0] pc, input logic [XL-1:0] tgt, input logic taken);
        rd_en      = 1'b0;
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = taken;
        tick("upd");
        upd_valid  = 1'b0;
    endtask

    function automatic logic [XL-1:0] rand_pc();
        return 32'h1000 + XL'($urandom_range(0, 3)) * 32 + XL'($urandom_range(0, 7)) * 4
               + XL'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1'b1; rd_en = 1'b0; rd_pc = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_target = '0; upd_taken = 1'b0; inv_all = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rd_pc = 32'h1000;
        #2;
        check_out("in_reset", 1'b0, 1'b0, '0);
        tick("in_reset");
        tick("in_reset2");
        rst = 1'b0;

        probe(32'h1000, 1'b0, 1'b0, 32'h0, "cold_miss");

        upd(32'h1000, 32'h2000, 1'b1);
        probe(32'h1000, 1'b1, 1'b1, 32'h2000, "alloc");

        upd(32'h1000, 32'h9999, 1'b0);
        probe(32'h1000, 1'b1, 1'b0, 32'h2000, "nt1");
        upd(32'h1000, 32'h9999, 1'b0);
        probe(32'h1000, 1'b1, 1'b0, 32'h2000, "nt2");
        upd(32'h1000, 32'h9999, 1'b0);
        probe(32'h1000, 1'b1, 1'b0, 32'h2000, "nt3");

        upd(32'h1020, 32'h4000, 1'b1);
        probe(32'h1000, 1'b1, 1'b0, 32'h2000, "read_old");
        upd(32'h1040, 32'h5000, 1'b1);
        probe(32'h1020, 1'b0, 1'b0, 32'h0,    "evicted");
        probe(32'h1000, 1'b1, 1'b0, 32'h2000, "kept");
        probe(32'h1040, 1'b1, 1'b1, 32'h5000, "new");

        // Lookup and update of the same PC in one cycle.
        rd_pc = 32'h3000; rd_en = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h3000; upd_target = 32'h6000; upd_taken = 1'b1;
        #2;
`ifdef BTB_BYPASS_EN
        check_out("same_cycle", 1'b1, 1'b1, 32'h6000);
`else
        check_out("same_cycle", 1'b0, 1'b0, 32'h0);
`endif
        tick("same_cycle");
        probe(32'h3000, 1'b1, 1'b1, 32'h6000, "after_same");

        // Invalidate-all wins over a concurrent update.
        rd_en = 1'b0; upd_valid = 1'b1; upd_pc = 32'h1080; upd_target = 32'h7000;
        upd_taken = 1'b1; inv_all = 1'b1;
        tick("inv");
        inv_all = 1'b0;
        probe(32'h1000, 1'b0, 1'b0, 32'h0, "inv_a");
        probe(32'h1040, 1'b0, 1'b0, 32'h0, "inv_b");
        probe(32'h3000, 1'b0, 1'b0, 32'h0, "inv_c");
        probe(32'h1080, 1'b0, 1'b0, 32'h0, "inv_d");

        // Reset mid-traffic: outputs held low, the concurrent update lost.
        upd(32'h1000, 32'h7000, 1'b1);
        rst = 1'b1; rd_pc = 32'h1000; rd_en = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h1100; upd_target = 32'h8000; upd_taken = 1'b1;
        #2;
        check_out("mid_rst", 1'b0, 1'b0, 32'h0);
        tick("mid_rst");
        #2;
        check_out("mid_rst2", 1'b0, 1'b0, 32'h0);
        tick("mid_rst2");
        rst = 1'b0;
        probe(32'h1000, 1'b0, 1'b0, 32'h0, "post_rst_a");
        probe(32'h1100, 1'b0, 1'b0, 32'h0, "post_rst_b");

        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 299) == 0);
            inv_all    = ($urandom_range(0, 149) == 0);
            rd_en      = 1'($urandom_range(0, 1));
            rd_pc      = rand_pc();
            upd_pc     = ($urandom_range(0, 3) == 0) ? rd_pc : rand_pc();
            upd_valid  = 1'($urandom_range(0, 1));
            upd_taken  = ($urandom_range(0, 9) < 6);
            upd_target = $urandom;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
